// File: rtl/sp_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// sp_mem_port_arbiter
//
// Shares one single-port memory request port between NUM_REQ requesters.
// The memory side uses request/grant with a fixed one-cycle read latency.
// One requester is selected per cycle. If the memory withholds its grant,
// that selection is locked (HOLD) until the grant arrives. The registered
// response is then routed back to the requester that issued the transfer.
//
// Handshake: a transfer happens in the cycle where mem_req_o & mem_gnt_i is
// high. The winning requester sees gnt_o[k] in that same cycle. The requester
// keeps req/addr/we/be/wdata stable from raising req_i[k] until gnt_o[k].
// rvalid_o[k] pulses exactly one cycle after the grant, and rdata_o carries
// mem_rdata_i in that cycle.
//
// Configuration macro: SP_MEM_ARB_RR_EN
//   defined   - round-robin; the search starts after the last granted port
//   undefined - fixed priority; the lowest index wins and there is no pointer
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   req_i/gnt_o     per-requester request / one-hot grant
//   addr_i, we_i, be_i, wdata_i   packed per-requester payloads
//   rvalid_o        one-hot response valid, one cycle after the grant
//   rdata_o         shared read data (mem_rdata_i passed through)
//   mem_*           single-port memory request interface
//   dbg_state_o     current FSM state (0 = ARB, 1 = HOLD)
// -----------------------------------------------------------------------------
module sp_mem_port_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_i,
  output logic [NUM_REQ-1:0]               gnt_o,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    addr_i,
  input  logic [NUM_REQ-1:0]               we_i,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0]  be_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    wdata_i,
  output logic [NUM_REQ-1:0]               rvalid_o,
  output logic [DATA_WIDTH-1:0]            rdata_o,
  output logic                             mem_req_o,
  input  logic                             mem_gnt_i,
  output logic [ADDR_WIDTH-1:0]            mem_addr_o,
  output logic                             mem_we_o,
  output logic [DATA_WIDTH/8-1:0]          mem_be_o,
  output logic [DATA_WIDTH-1:0]            mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]            mem_rdata_i,
  output logic                             dbg_state_o
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam int IDW  = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [IDW-1:0] r_held_id;
  logic           r_resp_valid;
  logic [IDW-1:0] r_resp_id;

  logic [IDW-1:0] w_arb_id;
  logic [IDW-1:0] w_sel;
  logic           w_mem_req;
  logic           w_xfer;

  // ---------------------------------------------------------------------------
  // Selection in ARB
  // ---------------------------------------------------------------------------
`ifdef SP_MEM_ARB_RR_EN
  logic [IDW-1:0] r_ptr;
  logic [IDW:0]   w_sum;
  logic [IDW-1:0] w_cand;

  // The loop walks from the farthest offset to the nearest one, so the last
  // hit is the first requester after r_ptr in wrap-around order. The wrap is
  // modulo NUM_REQ, which need not be a power of two.
  always_comb begin
    w_arb_id = '0;
    w_sum    = '0;
    w_cand   = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      w_sum = {1'b0, r_ptr} + (IDW+1)'(i);
      if (w_sum >= (IDW+1)'(NUM_REQ)) begin
        w_sum = w_sum - (IDW+1)'(NUM_REQ);
      end
      w_cand = w_sum[IDW-1:0];
      if (req_i[w_cand]) begin
        w_arb_id = w_cand;
      end
    end
  end

  // Reset value NUM_REQ-1 gives port 0 first priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= IDW'(NUM_REQ - 1);
    end else if (w_xfer) begin
      r_ptr <= w_sel;
    end
  end
`else
  // Fixed priority: the descending walk leaves the lowest requesting index.
  always_comb begin
    w_arb_id = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        w_arb_id = IDW'(i);
      end
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // FSM: ARB computes a selection; HOLD locks it while the grant is withheld.
  // ---------------------------------------------------------------------------
  assign w_sel = (r_state == ST_HOLD) ? r_held_id : w_arb_id;

  // mem_req_o is forced low combinationally during reset.
  assign w_mem_req = rst ? 1'b0 :
                     (r_state == ST_HOLD) ? req_i[r_held_id] : (|req_i);
  assign w_xfer    = w_mem_req & mem_gnt_i;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ARB:  if (w_mem_req && !mem_gnt_i) w_state_nxt = ST_HOLD;
      ST_HOLD: if (mem_gnt_i)               w_state_nxt = ST_ARB;
      default: w_state_nxt = ST_ARB;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_ARB;
      r_held_id    <= '0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_ARB && w_mem_req && !mem_gnt_i) begin
        r_held_id <= w_sel;
      end
      r_resp_valid <= w_xfer;
      if (w_xfer) begin
        r_resp_id <= w_sel;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Payload mux, grant and response routing
  // ---------------------------------------------------------------------------
  // The payload is zero whenever no request is presented, which also gives
  // all-zero memory outputs during reset.
  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    gnt_o       = '0;
    rvalid_o    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_mem_req && w_sel == IDW'(k)) begin
        mem_addr_o  = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        mem_we_o    = we_i[k];
        mem_be_o    = be_i[k*BE_W +: BE_W];
        mem_wdata_o = wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
      gnt_o[k]    = w_xfer && (w_sel == IDW'(k));
      rvalid_o[k] = r_resp_valid && (r_resp_id == IDW'(k));
    end
  end

  assign mem_req_o   = w_mem_req;
  assign rdata_o     = mem_rdata_i;
  assign dbg_state_o = r_state;

endmodule
